// File: rtl/fetch_unit_pkg.sv
// Shared constants for the RV32I instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// DEPTH does not need to be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: sequential PC generation, credit-limited imem requests,
// instruction buffering toward ID, and redirect/flush handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  INST_LEN = 32,
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                  DEPTH    = 3
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  input  logic                redirect_valid,
  input  logic [DATA_LEN-1:0] redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INST_LEN-1:0] id_inst,
  output logic [DATA_LEN-1:0] id_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IQ_W  = INST_LEN + DATA_LEN;

  logic [DATA_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    outstanding_next;
  logic [CNT_W-1:0]    iq_count;
  logic [CNT_W:0]      credits_used;
  logic [DATA_LEN-1:0] pcq_head;
  logic [IQ_W-1:0]     iq_head;
  logic                req_fire;
  logic                iq_push;
  logic                iq_pop;

  // The PC queue holds exactly one entry per in-flight request, so its
  // count is the outstanding-request counter.
  assign credits_used   = {1'b0, outstanding} + {1'b0, iq_count};
  assign imem_req_valid = !rst && (credits_used < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign iq_push = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign iq_pop  = id_valid && id_ready && !redirect_valid;

  assign id_valid = (iq_count != '0);
  assign id_inst  = id_valid ? iq_head[IQ_W-1:DATA_LEN] : INST_LEN'(NOP_INST);
  assign id_pc    = id_valid ? iq_head[DATA_LEN-1:0] : '0;

  // On redirect every request still in flight, including one accepted this
  // cycle, belongs to the old path and must be discarded on return.
  always_comb begin
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    fetch_pc_d       = fetch_pc_q;
    drop_cnt_d       = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~DATA_LEN'(3);
      drop_cnt_d = outstanding_next;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + DATA_LEN'(4);
      end
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_LEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_resp_valid),
    .flush     (1'b0),
    .head      (pcq_head),
    .count     (outstanding)
  );

  fetch_fifo #(
    .WIDTH (IQ_W),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (iq_push),
    .push_data ({imem_resp_data, pcq_head}),
    .pop       (iq_pop),
    .flush     (redirect_valid),
    .head      (iq_head),
    .count     (iq_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, variable-latency memory
// model and a monitor that tracks the expected PC stream toward ID.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .INST_LEN (32),
    .DATA_LEN (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_inst         (id_inst),
    .id_pc           (id_pc)
  );

  int          checkCount = 0;
  int          failCount  = 0;
  int          monCount   = 0;
  logic [31:0] expPc      = 32'h0;

  // Distinct, easily recognisable instruction word per address
  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0003;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstIn, input logic readyIn,
                               input logic idReadyIn, input logic rdrValidIn,
                               input logic [31:0] rdrPcIn);
    rst            = rstIn;
    imem_req_ready = readyIn;
    id_ready       = idReadyIn;
    redirect_valid = rdrValidIn;
    redirect_pc    = rdrPcIn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: in-order, never back-pressured, reset with the DUT
  int          memLatency = 1;
  int          cyc        = 0;
  int          lastDue    = 0;
  bit          accSeen    = 1'b0;
  logic [31:0] accAddr    = 32'h0;
  logic [31:0] pendAddr[$];
  int          pendDue[$];

  always @(negedge clk) begin
    accSeen = !rst && imem_req_valid && imem_req_ready;
    accAddr = imem_req_addr;
  end

  initial begin
    int due;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pendAddr.delete();
        pendDue.delete();
        lastDue = 0;
      end else if (accSeen) begin
        due = cyc + memLatency - 1;
        if (due < lastDue) due = lastDue;
        lastDue = due;
        pendAddr.push_back(accAddr);
        pendDue.push_back(due);
      end
      #2;
      if (!rst && pendAddr.size() > 0 && pendDue[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memData(pendAddr.pop_front());
        void'(pendDue.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
    end
  end

  // ID-side monitor: every accepted instruction must follow expPc
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !redirect_valid && id_valid && id_ready) begin
        checkOutput("monPc", id_pc, expPc);
        checkOutput("monInst", id_inst, memData(expPc));
        expPc = expPc + 32'd4;
        monCount++;
      end
    end
  end

  initial begin
    int  stallAccepts;
    bit  found;

    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rstReqValid", imem_req_valid, 0);
    checkOutput("rstIdValid", id_valid, 0);
    checkOutput("rstIdInst", id_inst, 32'h0000_0013);
    checkOutput("rstIdPc", id_pc, 0);
    tick();

    // Release: addresses 0,4,8,...; id_valid from cycle 2
    expPc = 32'h0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    for (int c = 0; c < 6; c++) begin
      checkOutput("seqReqValid", imem_req_valid, 1);
      checkOutput("seqAddr", imem_req_addr, 32'(4 * c));
      checkOutput("seqIdValid", id_valid, (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        checkOutput("seqIdPc", id_pc, 32'(4 * (c - 2)));
        checkOutput("seqIdInst", id_inst, memData(32'(4 * (c - 2))));
      end
      tick();
    end

    // Stall for 10 cycles: head held, credits run out
    stallAccepts = 0;
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) stallAccepts++;
      checkOutput("stallIdValid", id_valid, 1);
      checkOutput("stallIdPc", id_pc, expPc);
      checkOutput("stallIdInst", id_inst, memData(expPc));
      tick();
    end
    checkOutput("stallAccepts", (stallAccepts <= 3) ? 1 : 0, 1);
    checkOutput("stallReqValid", imem_req_valid, 0);
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Redirect to 0x100 while requests are in flight
    memLatency = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      #2;
      if (pendAddr.size() >= 2) found = 1'b1;
    end
    checkOutput("rdr1InFlight", found, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    expPc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    checkOutput("rdr1IdFlushed", id_valid, 0);
    checkOutput("rdr1Addr", imem_req_addr, 32'h0000_0100);
    for (int i = 0; i < 20 && !id_valid; i++) tick();
    checkOutput("rdr1Seen", id_valid, 1);
    checkOutput("rdr1IdPc", id_pc, 32'h0000_0100);
    checkOutput("rdr1IdInst", id_inst, memData(32'h0000_0100));
    memLatency = 1;
    for (int i = 0; i < 8; i++) tick();

    // Redirect to 0x203 in a cycle with both an accept and a response
    #2;
    checkOutput("rdr2Accept", imem_req_valid && imem_req_ready, 1);
    checkOutput("rdr2Resp", imem_resp_valid, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
    expPc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    checkOutput("rdr2Addr", imem_req_addr, 32'h0000_0200);
    checkOutput("rdr2IdFlushed", id_valid, 0);
    tick();
    checkOutput("rdr2StaleDropped", id_valid, 0);
    tick();
    checkOutput("rdr2IdValid", id_valid, 1);
    checkOutput("rdr2IdPc", id_pc, 32'h0000_0200);
    for (int i = 0; i < 4; i++) tick();

    // PC wrap past 0xFFFF_FFFC
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    expPc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    checkOutput("wrapAddr0", imem_req_addr, 32'hFFFF_FFF8);
    tick();
    checkOutput("wrapAddr1", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrapReqValid", imem_req_valid, 1);
    checkOutput("wrapAddr2", imem_req_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) tick();

    // Reset mid-stream with a full instruction queue
    id_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("fullIdValid", id_valid, 1);
    checkOutput("fullReqValid", imem_req_valid, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("midRstIdValid", id_valid, 0);
    checkOutput("midRstIdInst", id_inst, 32'h0000_0013);
    checkOutput("midRstIdPc", id_pc, 0);
    checkOutput("midRstReqValid", imem_req_valid, 0);
    expPc = 32'h0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("restartReqValid", imem_req_valid, 1);
    checkOutput("restartAddr", imem_req_addr, 32'h0000_0000);
    for (int i = 0; i < 8; i++) tick();

    checkOutput("monActive", (monCount > 15) ? 1 : 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
